// File: rtl/executa_movimentos_pkg.sv
// Shared move codes and sequencer state encodings for executa_movimentos,
// recebe_movimentos and their benches.
package executa_movimentos_pkg;

   localparam logic [2:0] FACE0      = 3'd0;
   localparam logic [2:0] FACE1      = 3'd1;
   localparam logic [2:0] FACE2      = 3'd2;
   localparam logic [2:0] FACE3      = 3'd3;
   localparam logic [2:0] FACE4      = 3'd4;
   localparam logic [2:0] FACE5      = 3'd5;
   localparam logic [2:0] INVALIDO   = 3'b110;
   localparam logic [2:0] TERMINADOR = 3'b111;

   typedef enum logic [3:0] {
      INICIAL      = 4'd0,
      ZERA         = 4'd1,
      LE           = 4'd2,
      ESPERA_MEM   = 4'd3,
      DECODIFICA   = 4'd4,
      ACIONA       = 4'd5,
      ESPERA_MOTOR = 4'd6,
      PROXIMO      = 4'd7,
      FIM          = 4'd8,
      ERRO         = 4'd9
   } estado_t;

   // A face move is any code from FACE0 to FACE5.
   function automatic logic movimento_valido(input logic [2:0] codigo);
      return codigo <= FACE5;
   endfunction

endpackage

// File: rtl/executa_movimentos_contador_m.sv
// Per-move timeout counter: counts up while enabled, flags the last count
// (M-1) and holds there until cleared.
module contador_m #(
   parameter int M = 50_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);

   localparam int W = (M > 1) ? $clog2(M) : 1;
   localparam logic [W-1:0] ULTIMO = W'(M - 1);

   logic [W-1:0] valor_q, valor_d;

   // Next count: clear has priority, saturate at the terminal value.
   always_comb begin
      valor_d = valor_q;
      if (zera) begin
         valor_d = '0;
      end else if (conta && (valor_q != ULTIMO)) begin
         valor_d = valor_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valor_q <= '0;
      end else begin
         valor_q <= valor_d;
      end
   end

   assign fim = (valor_q == ULTIMO);

endmodule

// File: rtl/executa_movimentos.sv
// Move-list sequencer: walks the move memory from address 0, commands each
// face move to the actuator and waits for its completion pulse, stopping on
// the terminator, an invalid code, a timeout or the end of memory.
//
// state        | meaning
// -------------+----------------------------------------------------
// INICIAL      | idle after reset, waiting for iniciar
// ZERA         | clear address, move count and timeout
// LE           | present mem_addr to the move memory
// ESPERA_MEM   | memory read latency cycle
// DECODIFICA   | classify mem_dado: move, invalid or terminator
// ACIONA       | one-cycle motor_partida pulse, timeout cleared
// ESPERA_MOTOR | wait for motor_fim, bounded by TIMEOUT cycles
// PROXIMO      | count the move, advance address or stop at the end
// FIM          | list completed (pronto)
// ERRO         | invalid code, timeout or missing terminator (erro)
module executa_movimentos
   import executa_movimentos_pkg::*;
#(
   parameter int ADDR_W  = 6,
   parameter int TIMEOUT = 50_000_000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic [2:0]        mem_dado,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        motor_codigo,
   output logic              motor_partida,
   input  logic              motor_fim,
   output logic [ADDR_W:0]   n_movimentos,
   output logic              pronto,
   output logic              erro,
   output logic [3:0]        db_estado
);

   estado_t           estado_q, estado_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   n_q, n_d;
   logic [2:0]        codigo_q, codigo_d;
   logic              partida_q, partida_d;
   logic              pronto_q, pronto_d;
   logic              erro_q, erro_d;

   logic tmo_zera, tmo_conta, tmo_fim;

   assign tmo_zera  = (estado_q == ZERA) || (estado_q == ACIONA);
   assign tmo_conta = (estado_q == ESPERA_MOTOR);

   contador_m #(.M(TIMEOUT)) u_timeout (
      .clock (clock),
      .reset (reset),
      .zera  (tmo_zera),
      .conta (tmo_conta),
      .fim   (tmo_fim)
   );

   // Next state and datapath; outputs are decoded from the next state so
   // they are registered alongside it.
   always_comb begin
      estado_d = estado_q;
      addr_d   = addr_q;
      n_d      = n_q;
      codigo_d = codigo_q;
      case (estado_q)
         INICIAL: begin
            if (iniciar) estado_d = ZERA;
         end
         ZERA: begin
            addr_d   = '0;
            n_d      = '0;
            estado_d = LE;
         end
         LE:         estado_d = ESPERA_MEM;
         ESPERA_MEM: estado_d = DECODIFICA;
         DECODIFICA: begin
            if (mem_dado == TERMINADOR) begin
               estado_d = FIM;
            end else if (!movimento_valido(mem_dado)) begin
               estado_d = ERRO;
            end else begin
               codigo_d = mem_dado;
               estado_d = ACIONA;
            end
         end
         ACIONA: estado_d = ESPERA_MOTOR;
         ESPERA_MOTOR: begin
            // Completion beats a timeout landing on the same cycle.
            if (motor_fim) begin
               estado_d = PROXIMO;
            end else if (tmo_fim) begin
               estado_d = ERRO;
            end
         end
         PROXIMO: begin
            n_d = n_q + 1'b1;
            // Last address without a terminator: no wrap-around.
            if (addr_q == '1) begin
               estado_d = ERRO;
            end else begin
               addr_d   = addr_q + 1'b1;
               estado_d = LE;
            end
         end
         FIM, ERRO: begin
            if (iniciar) estado_d = ZERA;
         end
         default: estado_d = INICIAL;
      endcase
      partida_d = (estado_d == ACIONA);
      pronto_d  = (estado_d == FIM);
      erro_d    = (estado_d == ERRO);
   end

   // State, datapath and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q  <= INICIAL;
         addr_q    <= '0;
         n_q       <= '0;
         codigo_q  <= '0;
         partida_q <= 1'b0;
         pronto_q  <= 1'b0;
         erro_q    <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         addr_q    <= addr_d;
         n_q       <= n_d;
         codigo_q  <= codigo_d;
         partida_q <= partida_d;
         pronto_q  <= pronto_d;
         erro_q    <= erro_d;
      end
   end

   assign mem_addr      = addr_q;
   assign motor_codigo  = codigo_q;
   assign motor_partida = partida_q;
   assign n_movimentos  = n_q;
   assign pronto        = pronto_q;
   assign erro          = erro_q;
   assign db_estado     = estado_q;

endmodule

// File: doc/executa_movimentos.md
EXECUTA_MOVIMENTOS -- requirements
Module: executa_movimentos

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, which is the move-memory address width (64 entries).
REQ-002 The block SHALL have parameter TIMEOUT, default 50_000_000, which is the maximum number of clock cycles allowed per move for motor_fim to arrive.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 The block SHALL have port iniciar, input, 1 bit: starts execution of the stored move list.
REQ-006 The block SHALL have port mem_dado, input, 3 bits: the move code read from move memory, valid 1 cycle after mem_addr changes.
REQ-007 The block SHALL have port mem_addr, output, ADDR_W bits: the move-memory read address.
REQ-008 The block SHALL have port motor_codigo, output, 3 bits: the move being commanded to the actuator datapath.
REQ-009 The block SHALL have port motor_partida, output, 1 bit: a one-cycle start pulse to the actuator.
REQ-010 The block SHALL have port motor_fim, input, 1 bit: the actuator completion pulse.
REQ-011 The block SHALL have port n_movimentos, output, ADDR_W+1 bits: the count of moves completed in the current run.
REQ-012 The block SHALL have port pronto, output, 1 bit: high while in FIM.
REQ-013 The block SHALL have port erro, output, 1 bit: high while in ERRO.
REQ-014 The block SHALL have port db_estado, output, 4 bits: the current state code, for debug display.

Function
REQ-015 Move codes SHALL be: 0-5 valid face moves, 3'b110 invalid, 3'b111 end-of-list terminator.
REQ-016 States SHALL be INICIAL=0, ZERA=1, LE=2, ESPERA_MEM=3, DECODIFICA=4, ACIONA=5, ESPERA_MOTOR=6, PROXIMO=7, FIM=8, ERRO=9; db_estado equals the current code.
REQ-017 INICIAL SHALL go to ZERA when iniciar=1, and stay otherwise.
REQ-018 ZERA SHALL clear mem_addr, n_movimentos and the timeout counter in one cycle, then go to LE.
REQ-019 LE SHALL present mem_addr for one cycle, then go to ESPERA_MEM; DECODIFICA SHALL sample mem_dado (read latency exactly 1 cycle).
REQ-020 In DECODIFICA, code 3'b111 SHALL go to FIM, code 3'b110 SHALL go to ERRO, and codes 0-5 SHALL latch motor_codigo and go to ACIONA.
REQ-021 ACIONA SHALL assert motor_partida for exactly one cycle, clear the timeout counter, and go to ESPERA_MOTOR.
REQ-022 ESPERA_MOTOR SHALL increment the timeout counter each cycle; motor_fim=1 SHALL go to PROXIMO, and counter reaching TIMEOUT-1 without motor_fim SHALL go to ERRO.
REQ-023 When motor_fim and timeout expiry coincide, motor_fim SHALL win (go to PROXIMO).
REQ-024 PROXIMO SHALL increment n_movimentos; if mem_addr = 2^ADDR_W-1 it SHALL go to ERRO (list without terminator, no wrap-around), otherwise it SHALL increment mem_addr and go to LE.
REQ-025 motor_fim outside ESPERA_MOTOR SHALL be ignored, and iniciar outside INICIAL/FIM/ERRO SHALL be ignored.
REQ-026 FIM and ERRO SHALL hold, and iniciar=1 in either SHALL go to ZERA (restart from address 0).
REQ-027 motor_codigo SHALL hold its last latched value until the next DECODIFICA with a valid move.
REQ-028 n_movimentos SHALL hold its value in FIM/ERRO until the next ZERA.

Reset
REQ-029 Reset SHALL force state INICIAL immediately, regardless of clock.
REQ-030 Reset SHALL set mem_addr, motor_codigo, n_movimentos and the timeout counter to 0, and motor_partida, pronto and erro to 0.
REQ-031 Reset mid-move SHALL abandon the move without emitting further motor_partida pulses.

Structure
REQ-032 Move codes (FACE0-5, INVALIDO, TERMINADOR) and state encodings SHALL live in a shared package/header, reused by recebe_movimentos and test benches.
REQ-033 The FSM and datapath (address counter, move counter, code register) SHALL be a single module.
REQ-034 The timeout SHALL use one sub-module, contador_m (parameter M=TIMEOUT, inputs zera/conta, output fim).

Verification
REQ-035 The bench SHALL cover: memory {2,0,5,7}, motor_fim 10 cycles after each partida -> three partida pulses with codes 2,0,5, pronto=1, n_movimentos=3, mem_addr=3.
REQ-036 The bench SHALL cover: memory {1,6}, TIMEOUT=20 -> one move executed, then erro=1, db_estado=9, n_movimentos=1.
REQ-037 The bench SHALL cover: memory {3,7}, motor_fim never arrives, TIMEOUT=20 -> erro=1 exactly 20 cycles after ESPERA_MOTOR entry, n_movimentos=0.
REQ-038 The bench SHALL cover: ADDR_W=2, memory {0,1,2,3} with no terminator -> four moves, then erro=1, n_movimentos=4, mem_addr=3.
REQ-039 The bench SHALL cover: reset asserted during ESPERA_MOTOR of move 2 -> all outputs 0 and db_estado=0 immediately; a later iniciar re-runs from address 0.
REQ-040 The bench SHALL cover: iniciar pulsed during ESPERA_MOTOR, and motor_fim and timeout coinciding -> the iniciar is ignored, and the coincidence resolves to PROXIMO.
